// File: rtl/flash_pf_pkg.sv
// Shared definitions for the flash line prefetcher: FSM encoding and
// line-address arithmetic.
package flash_pf_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_DMD     = 3'd1,
    ST_PF      = 3'd2,
    ST_PF_HIT  = 3'd3,
    ST_PF_MISS = 3'd4
  } pf_state_e;

  localparam int          LINE_BYTES    = 16;
  localparam logic [23:0] NEXT_LINE_INC = 24'h10;

  function automatic logic [19:0] line_tag(input logic [23:0] addr);
    return addr[23:4];
  endfunction

endpackage

// File: rtl/flash_line_prefetch.sv
// Demand line fetcher with a one-line next-line prefetch buffer in front of
// a single-outstanding flash reader.
module flash_line_prefetch
  import flash_pf_pkg::*;
#(
  parameter int LINE_SIZE = 128,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [23:0]          req_addr,
  input  logic                 req_rd,
  output logic                 req_done,
  output logic [LINE_SIZE-1:0] req_line,
  output logic [23:0]          fr_addr,
  output logic                 fr_rd,
  input  logic                 fr_done,
  input  logic [LINE_SIZE-1:0] fr_line,
  input  logic                 pf_en,
  input  logic                 flush,
  output logic [CNT_W-1:0]     pf_hits,
  output logic [2:0]           dbg_state_o
);

  // Handshake: req_rd/fr_rd/fr_done/req_done are single-cycle strobes with no
  // back-pressure; fr_line is only meaningful in the fr_done cycle.
  pf_state_e              state_q, state_d;
  logic                   req_done_q, req_done_d;
  logic [LINE_SIZE-1:0]   req_line_q, req_line_d;
  logic [23:0]            fr_addr_q, fr_addr_d;
  logic                   fr_rd_q, fr_rd_d;
  logic                   pf_valid_q, pf_valid_d;
  logic [19:0]            pf_tag_q, pf_tag_d;
  logic [LINE_SIZE-1:0]   pf_line_q, pf_line_d;
  logic [CNT_W-1:0]       pf_hits_q, pf_hits_d;
  logic [23:0]            pend_addr_q, pend_addr_d;
  logic [23:0]            served_q, served_d;
  logic                   flushed_q, flushed_d;

  logic                   launch, buf_hit, fr_match, fill_hit, fill;
  logic [CNT_W-1:0]       hits_inc;

  assign launch   = (state_q == ST_IDLE) && req_done_q && pf_en;
  assign buf_hit  = pf_valid_q && !flush && (line_tag(req_addr) == pf_tag_q);
  assign fr_match = line_tag(req_addr) == line_tag(fr_addr_q);
  // A demand racing the prefetch completion sees the line it is filling.
  assign fill_hit = !flushed_q && !flush && fr_match;
  assign fill     = fr_done && (state_q inside {ST_PF, ST_PF_HIT, ST_PF_MISS});
  assign hits_inc = (&pf_hits_q) ? pf_hits_q : pf_hits_q + CNT_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (launch)                  state_d = ST_PF;
        else if (req_rd && !buf_hit) state_d = ST_DMD;
      end
      ST_DMD:     if (fr_done) state_d = ST_IDLE;
      ST_PF: begin
        if (fr_done)     state_d = (req_rd && !fill_hit) ? ST_DMD : ST_IDLE;
        else if (req_rd) state_d = fr_match ? ST_PF_HIT : ST_PF_MISS;
      end
      ST_PF_HIT:  if (fr_done) state_d = ST_IDLE;
      ST_PF_MISS: if (fr_done) state_d = ST_DMD;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    req_done_d  = 1'b0;
    fr_rd_d     = 1'b0;
    req_line_d  = req_line_q;
    fr_addr_d   = fr_addr_q;
    pf_valid_d  = pf_valid_q;
    pf_tag_d    = pf_tag_q;
    pf_line_d   = pf_line_q;
    pf_hits_d   = pf_hits_q;
    pend_addr_d = pend_addr_q;
    served_d    = served_q;
    flushed_d   = flushed_q;
    if (fill) begin
      pf_line_d  = fr_line;
      pf_tag_d   = line_tag(fr_addr_q);
      pf_valid_d = !flushed_q;
    end
    case (state_q)
      ST_IDLE: begin
        if (launch) begin
          fr_rd_d    = 1'b1;
          fr_addr_d  = served_q + NEXT_LINE_INC;
          pf_valid_d = 1'b0;
          flushed_d  = 1'b0;
        end else if (req_rd && buf_hit) begin
          req_done_d = 1'b1;
          req_line_d = pf_line_q;
          served_d   = req_addr;
          pf_hits_d  = hits_inc;
        end else if (req_rd) begin
          fr_rd_d   = 1'b1;
          fr_addr_d = req_addr;
        end
      end
      ST_DMD: begin
        if (fr_done) begin
          req_done_d = 1'b1;
          req_line_d = fr_line;
          served_d   = fr_addr_q;
        end
      end
      ST_PF: begin
        if (fr_done && req_rd && fill_hit) begin
          req_done_d = 1'b1;
          req_line_d = fr_line;
          served_d   = req_addr;
          pf_hits_d  = hits_inc;
        end else if (fr_done && req_rd) begin
          fr_rd_d   = 1'b1;
          fr_addr_d = req_addr;
        end else if (!fr_done && req_rd && !fr_match) begin
          pend_addr_d = req_addr;
        end
      end
      ST_PF_HIT: begin
        if (fr_done) begin
          req_done_d = 1'b1;
          req_line_d = fr_line;
          served_d   = fr_addr_q;
          pf_hits_d  = hits_inc;
        end
      end
      ST_PF_MISS: begin
        if (fr_done) begin
          fr_rd_d   = 1'b1;
          fr_addr_d = pend_addr_q;
        end
      end
      default: ;
    endcase
    // Flush wins over a fill on the same edge and poisons the flight in progress.
    if (flush) begin
      pf_valid_d = 1'b0;
      if (!launch) flushed_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_done_q  <= 1'b0;
      req_line_q  <= '0;
      fr_addr_q   <= '0;
      fr_rd_q     <= 1'b0;
      pf_valid_q  <= 1'b0;
      pf_tag_q    <= '0;
      pf_line_q   <= '0;
      pf_hits_q   <= '0;
      pend_addr_q <= '0;
      served_q    <= '0;
      flushed_q   <= 1'b0;
    end else begin
      req_done_q  <= req_done_d;
      req_line_q  <= req_line_d;
      fr_addr_q   <= fr_addr_d;
      fr_rd_q     <= fr_rd_d;
      pf_valid_q  <= pf_valid_d;
      pf_tag_q    <= pf_tag_d;
      pf_line_q   <= pf_line_d;
      pf_hits_q   <= pf_hits_d;
      pend_addr_q <= pend_addr_d;
      served_q    <= served_d;
      flushed_q   <= flushed_d;
    end
  end

  assign req_done    = req_done_q;
  assign req_line    = req_line_q;
  assign fr_addr     = fr_addr_q;
  assign fr_rd       = fr_rd_q;
  assign pf_hits     = pf_hits_q;
  assign dbg_state_o = state_q;

endmodule
